reg_dump_ctrl: RTL and testbench
================================

# reg_dump_ctrl

Debug-unit sequencer that walks the ID-stage register file through its debug read port and streams every register out as bytes over a valid/ready byte channel, normally the UART transmitter. On a start request it holds the pipeline, reads registers 0..N_REGS-1 one at a time, and emits each one as NB_REG/8 bytes, least-significant byte first. It then pulses done and releases the pipeline. It sits between the debug unit's command decoder, the register file debug port (address out, data in) and the UART TX.

## Interface
- NB_REG, 32, register width; must be a multiple of 8
- NB_ADDR, 5, register address width
- N_REGS, 32, registers dumped; at most 2^NB_ADDR

- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  dump request; sampled only in IDLE
- i_dunit_reg  in  NB_REG  register file debug read data; combinational read of o_dunit_addr
- i_tx_ready  in  1  byte sink can accept
- o_dunit_addr  out  NB_ADDR  register file debug read address
- o_tx_data  out  8  byte to send
- o_tx_valid  out  1  o_tx_data valid
- o_busy  out  1  dump in progress
- o_pipe_hold  out  1  freezes the pipeline; the debug unit drives the inverse into the stage clock enables
- o_done  out  1  one-cycle pulse at end of dump

## Operation
- States: IDLE, LOAD, SEND, (CSUM), DONE.
- **IDLE.** All outputs are 0. If i_start=1 at a clock edge, the next state is LOAD with the register index at 0.
- **LOAD.** o_dunit_addr = index. At the end of the cycle, i_dunit_reg is captured into the NB_REG shift register, the byte counter is cleared, and the next state is SEND.
- **SEND.** o_tx_valid=1 and o_tx_data = shift[7:0]. On a cycle with i_tx_ready=1:
  - the shift register moves right by 8 and the byte counter increments;
  - after byte NB_REG/8-1 the next state is LOAD with index+1;
  - after byte NB_REG/8-1 of index N_REGS-1 the next state is CSUM if configured, otherwise DONE.
- **Backpressure.** While i_tx_ready=0, o_tx_valid stays high and o_tx_data stays stable. No byte is dropped or duplicated.
- **DONE.** o_done=1 for exactly one cycle, then IDLE.
- **Status outputs.** o_busy and o_pipe_hold are 1 in every state except IDLE.
- **o_dunit_addr.** Holds the current index in LOAD and SEND, and 0 elsewhere.
- **Start during a dump.** i_start is ignored in every state except IDLE. A start asserted in the DONE cycle is lost.
- **Index width.** The index counter is NB_ADDR+1 bits wide, so it cannot wrap before the terminal compare.

## Timing
- Edge 0 samples i_start=1. With i_tx_ready held at 1:
  - register k is in LOAD in cycle 5k+1;
  - byte j of register k has o_tx_valid in cycle 5k+2+j (for NB_REG=32);
  - the last byte is in cycle 5·N_REGS; DONE is in cycle 5·N_REGS+1 (160 and 161 for defaults).
- Register data is sampled in LOAD only. Writes to a register after its LOAD cycle are not reflected in the dump. o_pipe_hold prevents such writes in normal use.
- Reset asserted at any time forces IDLE and all outputs to 0 immediately, without waiting for a clock edge. A partially sent stream is abandoned. A subsequent start restarts at register 0.
- No combinational path exists from i_tx_ready to o_tx_valid or o_tx_data. Both are decoded from registered state and the shift register only.

## Configuration
- **REG_DUMP_CHECKSUM_EN defined:**
  - an 8-bit XOR accumulator is cleared at start and XORs every accepted data byte;
  - CSUM state follows the last data byte and sends the accumulator with the same valid/ready handshake;
  - DONE follows acceptance of the checksum byte;
  - stream length is N_REGS·NB_REG/8 + 1 bytes.
- **Not defined:** no CSUM state, no accumulator, and SEND goes directly to DONE after the last register.

## Test plan
- **Basic dump.** All registers 0 except r1=0xDEADBEEF, i_tx_ready=1, pulse start → 128 bytes; bytes 4..7 = EF BE AD DE in cycles 7..10; all others 0x00; o_done pulses in cycle 161; o_busy and o_pipe_hold are high in cycles 1..161.
- **Backpressure.** Same data; hold i_tx_ready=0 for 10 cycles while byte 5 (0xBE) is valid → o_tx_data=0xBE and o_tx_valid=1 throughout; byte sequence identical to the basic dump; o_done is delayed by 10 cycles.
- **Ignored start.** Pulse i_start in cycles 20 and 161 → no restart; exactly 128 bytes; o_busy low in cycle 162.
- **Reset mid-dump.** Assert i_reset while byte 50 is valid → o_tx_valid, o_busy and o_pipe_hold drop before the next edge; release reset, pulse start → the stream restarts at r0 byte 0.
- **Checksum (REG_DUMP_CHECKSUM_EN).** Basic dump data → 129 bytes; final byte 0x22 (EF^BE^AD^DE); o_done pulses in cycle 162.
- **Address sequencing.** Register k preloaded with value k → o_dunit_addr = k throughout cycles 5k+1..5k+5; byte 4k = k; o_dunit_addr = 0 in IDLE and DONE.

Source files
------------

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: debug-unit sequencer that walks the register file through its
// debug read port and streams each register out LSB-first as bytes on a
// valid/ready channel, holding the pipeline for the duration of the dump.
// Optional feature: define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module reg_dump_ctrl #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  input  logic               i_tx_ready,
  output logic [NB_ADDR-1:0] o_dunit_addr,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_pipe_hold,
  output logic               o_done
);

  localparam int NBYTES = NB_REG / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  // One spare index bit so the counter cannot wrap before the terminal compare
  localparam int IW     = NB_ADDR + 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(N_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [BCW-1:0]    byte_cnt;
  logic [NB_REG-1:0] shift;
  logic              last_byte;
  logic              last_reg;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_reg  = (idx == LAST_IDX);

  // Sequencer: register index, byte counter and dump state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      idx      <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          byte_cnt <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (i_tx_ready) begin
            byte_cnt <= byte_cnt + BCW'(1);
            if (last_byte) begin
              if (last_reg) begin
`ifdef REG_DUMP_CHECKSUM_EN
                state <= CSUM;
`else
                state <= DONE;
`endif
              end else begin
                idx   <= idx + IW'(1);
                state <= LOAD;
              end
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (i_tx_ready) state <= DONE;
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Register capture in LOAD, then shift one byte out per accepted transfer
  always_ff @(posedge i_clk) begin
    if (state == LOAD) begin
      shift <= i_dunit_reg;
    end else if (state == SEND && i_tx_ready) begin
      shift <= shift >> 8;
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // Running XOR of every accepted data byte, cleared when a dump starts
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_start) begin
      csum <= '0;
    end else if (state == SEND && i_tx_ready) begin
      csum <= csum ^ shift[7:0];
    end
  end
`endif

  // Outputs decoded from registered state only; nothing depends on i_tx_ready
  always_comb begin
    o_tx_valid   = 1'b0;
    o_tx_data    = '0;
    o_dunit_addr = '0;
    o_done       = 1'b0;
    o_busy       = (state != IDLE);
    o_pipe_hold  = (state != IDLE);
    case (state)
      LOAD: o_dunit_addr = idx[NB_ADDR-1:0];
      SEND: begin
        o_tx_valid   = 1'b1;
        o_tx_data    = shift[7:0];
        o_dunit_addr = idx[NB_ADDR-1:0];
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        o_tx_valid = 1'b1;
        o_tx_data  = csum;
      end
`endif
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed testbench for reg_dump_ctrl (default parameters).
module tb_reg_dump_ctrl;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NBYTES_EXP = 128 + CS;
  localparam int DONE_C     = 161 + CS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] dreg;
  logic [4:0]  addr;
  logic [7:0]  tx_data;
  logic        valid;
  logic        busy;
  logic        hold;
  logic        done;

  logic [31:0] rf [32];

  int total = 0;
  int passed = 0;

  logic [7:0]  bytes [$];
  int          cyc_q [$];
  logic        busy_log [400];
  logic        hold_log [400];
  logic [4:0]  addr_log [400];
  int          done_cyc;
  int          done_cnt;
  int          stall_bad;

  always #5 clk = ~clk;

  assign dreg = rf[addr];

  reg_dump_ctrl dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_dunit_reg  (dreg),
    .i_tx_ready   (ready),
    .o_dunit_addr (addr),
    .o_tx_data    (tx_data),
    .o_tx_valid   (valid),
    .o_busy       (busy),
    .o_pipe_hold  (hold),
    .o_done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start at the next edge (edge 0), then log cycles 1..ncyc.
  task automatic run_dump(input int hold_byte, input int hold_len,
                          input int sa, input int sb, input int ncyc);
    int held = 0;
    bytes.delete();
    cyc_q.delete();
    done_cyc  = -1;
    done_cnt  = 0;
    stall_bad = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      start = (c == sa) || (c == sb);
      ready = 1'b1;
      if (bytes.size() == hold_byte && held < hold_len) begin
        ready = 1'b0;
        held++;
        if (!valid || tx_data !== 8'hBE) stall_bad++;
      end
      busy_log[c] = busy;
      hold_log[c] = hold;
      addr_log[c] = addr;
      if (valid && ready) begin
        bytes.push_back(tx_data);
        cyc_q.push_back(c);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      step();
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  // Compare the captured stream against the byte order derived from rf.
  task automatic check_stream(input string tag);
    logic [7:0] exp_b;
    logic [7:0] cs = 8'h00;
    int bad = 0;
    check({tag, "_len"}, 32'(bytes.size()), 32'(NBYTES_EXP));
    if (bytes.size() == NBYTES_EXP) begin
      for (int k = 0; k < 32; k++) begin
        for (int j = 0; j < 4; j++) begin
          exp_b = 8'(rf[k] >> (8 * j));
          cs = cs ^ exp_b;
          if (bytes[4 * k + j] !== exp_b) bad++;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      if (bytes[128] !== cs) bad++;
`endif
    end
    check({tag, "_bytes_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int bad_b;
    int bad_h;
    int n;
    int c;
    logic found;

    for (int k = 0; k < 32; k++) rf[k] = 32'h0;

    // Reset state
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic dump
    rf[1] = 32'hDEADBEEF;
    run_dump(-1, 0, -1, -1, 170);
    check_stream("basic");
    check("basic_r1", {bytes[7], bytes[6], bytes[5], bytes[4]}, 32'hDEADBEEF);
    check("basic_b4_cyc", 32'(cyc_q[4]), 32'd7);
    check("basic_b7_cyc", 32'(cyc_q[7]), 32'd10);
    check("basic_done_cyc", 32'(done_cyc), 32'(DONE_C));
    check("basic_done_cnt", 32'(done_cnt), 32'd1);
    bad_b = 0;
    bad_h = 0;
    for (int i = 1; i <= DONE_C; i++) begin
      if (busy_log[i] !== 1'b1) bad_b++;
      if (hold_log[i] !== 1'b1) bad_h++;
    end
    check("basic_busy_high", 32'(bad_b), 32'd0);
    check("basic_hold_high", 32'(bad_h), 32'd0);
    check("basic_busy_after", 32'(busy_log[DONE_C + 1]), 32'd0);
`ifdef REG_DUMP_CHECKSUM_EN
    check("basic_csum", 32'(bytes[128]), 32'h22);
`endif

    // Backpressure on byte 5
    run_dump(5, 10, -1, -1, 185);
    check("bp_stall_stable", 32'(stall_bad), 32'd0);
    check_stream("bp");
    check("bp_b5_cyc", 32'(cyc_q[5]), 32'd18);
    check("bp_done_cyc", 32'(done_cyc), 32'(DONE_C + 10));

    // Start pulses during the dump and in DONE are ignored
    run_dump(-1, 0, 20, DONE_C, 200);
    check_stream("ign");
    check("ign_done_cnt", 32'(done_cnt), 32'd1);
    check("ign_busy_after", 32'(busy_log[DONE_C + 1]), 32'd0);
    bad_b = 0;
    for (int i = DONE_C + 1; i <= 200; i++) begin
      if (busy_log[i] !== 1'b0) bad_b++;
    end
    check("ign_stays_idle", 32'(bad_b), 32'd0);

    // Reset while byte 50 is valid
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    c = 1;
    found = 1'b0;
    while (c <= 300 && !found) begin
      if (valid && n == 50) begin
        found = 1'b1;
      end else begin
        if (valid) n++;
        step();
        c++;
      end
    end
    check("mid_found", 32'(found), 32'd1);
    check("mid_b50_cyc", 32'(c), 32'd64);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_hold", 32'(hold), 32'd0);
    #2;
    rst = 1'b0;
    step();
    rf[0] = 32'h11223344;
    run_dump(-1, 0, -1, -1, 170);
    check("restart_b0", 32'(bytes[0]), 32'h44);
    check("restart_b0_cyc", 32'(cyc_q[0]), 32'd2);
    check_stream("restart");

    // Address sequencing: register k holds k
    for (int k = 0; k < 32; k++) rf[k] = 32'(k);
    check("addr_idle", 32'(addr), 32'd0);
    run_dump(-1, 0, -1, -1, 170);
    bad_b = 0;
    for (int k = 0; k < 32; k++) begin
      for (int i = 5 * k + 1; i <= 5 * k + 5; i++) begin
        if (addr_log[i] !== 5'(k)) bad_b++;
      end
    end
    check("addr_seq_bad", 32'(bad_b), 32'd0);
    check("addr_done", 32'(addr_log[DONE_C]), 32'd0);
    check("addr_byte12", 32'(bytes[12]), 32'd3);
    check_stream("addr");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
